// File: rtl/seq_ctrl_pkg.sv
// seq_pkg: shared state encoding and opcode constants for the 9-bit core sequencer
package seq_pkg;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  localparam logic [2:0] OP_LDI = 3'b000;
  localparam logic [2:0] OP_BR0 = 3'b011;
  localparam logic [2:0] OP_BR1 = 3'b101;
  localparam logic [2:0] OP_LD  = 3'b110;
  localparam logic [2:0] OP_ST  = 3'b111;
endpackage

// File: rtl/seq_ctrl_control.sv
// Control: opcode decoder; ALUOp in, ungated branch/RegWrite/MemRead/MemWrite enables out
module Control
  import seq_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic [OPW-1:0] ALUOp,
  output logic           branch,
  output logic           RegWrite,
  output logic           MemRead,
  output logic           MemWrite
);
  assign branch   = ALUOp == OPW'(OP_BR0) || ALUOp == OPW'(OP_BR1);
  assign MemRead  = ALUOp == OPW'(OP_LD);
  assign MemWrite = ALUOp == OPW'(OP_ST);
  assign RegWrite = !(branch || MemWrite);
endmodule

// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle FETCH/EXEC/MEM/WB sequencer owning PC and IR
// Ports: Clk/Reset (sync, active-high), Start handshake, Instr from ROM at PC, BrCond from ALU;
// PC, IR, gated strobes IRWrite/RegWrite/MemRead/MemWrite, Done, CycleCnt.
// SEQ_CYCLE_COUNT_EN builds the saturating execution-cycle counter; otherwise CycleCnt is 0.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int             OPW       = 3,
  parameter int             PCW       = 10,
  parameter int             MEM_LAT   = 1,
  parameter logic [8:0]     HALT_WORD = 9'h000
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           Start,
  input  logic [8:0]     Instr,
  input  logic           BrCond,
  output logic [PCW-1:0] PC,
  output logic [8:0]     IR,
  output logic           IRWrite,
  output logic           RegWrite,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           Done,
  output logic [15:0]    CycleCnt
);
  localparam int MCW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d, pc_inc, pc_br;
  logic [8:0]     ir_q, ir_d;
  logic [MCW-1:0] mcnt_q, mcnt_d;
  logic           c_branch, c_regwrite, c_memread, c_memwrite, mem_last;
  Control #(.OPW(OPW)) u_ctrl (
    .ALUOp   (ir_q[8 -: OPW]),
    .branch  (c_branch),
    .RegWrite(c_regwrite),
    .MemRead (c_memread),
    .MemWrite(c_memwrite)
  );
  assign mem_last = mcnt_q == MCW'(MEM_LAT - 1);
  assign pc_inc   = pc_q + 1'b1;
  assign pc_br    = pc_q + {{(PCW-6){ir_q[5]}}, ir_q[5:0]};
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      mcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      mcnt_q  <= mcnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    mcnt_d  = mcnt_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        state_d = Start ? S_FETCH : state_q;
        pc_d    = Start ? '0 : pc_q;
      end
      S_FETCH: begin
        ir_d    = Instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        mcnt_d = '0;
        if (ir_q == HALT_WORD) state_d = S_HALT;
        else if (c_branch) begin
          pc_d    = BrCond ? pc_br : pc_inc;
          state_d = S_FETCH;
        end else state_d = (c_memread || c_memwrite) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mcnt_d  = mem_last ? mcnt_q : mcnt_q + 1'b1;
        state_d = !mem_last ? S_MEM : c_memwrite ? S_FETCH : S_WB;
        pc_d    = (mem_last && c_memwrite) ? pc_inc : pc_q;
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  assign PC       = pc_q;
  assign IR       = ir_q;
  assign IRWrite  = state_q == S_FETCH;
  assign RegWrite = state_q == S_WB && c_regwrite;
  assign MemRead  = state_q == S_MEM && c_memread;
  assign MemWrite = state_q == S_MEM && c_memwrite && mem_last;
  assign Done     = state_q == S_HALT;
`ifdef SEQ_CYCLE_COUNT_EN
  logic [15:0] cnt_q;
  logic        run_cyc, start_run;
  assign start_run = Start && (state_q == S_IDLE || state_q == S_HALT);
  assign run_cyc   = state_q inside {S_FETCH, S_EXEC, S_MEM, S_WB};
  always_ff @(posedge Clk) begin
    if (Reset || start_run) cnt_q <= '0;
    else if (run_cyc && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 1'b1;
  end
  assign CycleCnt = cnt_q;
`else
  assign CycleCnt = '0;
`endif
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed table, corner sequences and random programs against an instruction-level model
module tb_seq_ctrl;
  localparam int L = 3;
  localparam logic [8:0] HW = 9'h000;
`ifdef SEQ_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif
  logic        Clk = 1'b0, Reset = 1'b1, Start = 1'b0, BrCond;
  logic [8:0]  Instr, IR;
  logic [9:0]  PC;
  logic        IRWrite, RegWrite, MemRead, MemWrite, Done;
  logic [15:0] CycleCnt;
  logic [8:0]  rom [1024];
  logic        brc [1024];
  int          n_pass = 0, n_tot = 0;
  assign Instr  = rom[PC];
  assign BrCond = brc[PC];
  seq_ctrl #(.MEM_LAT(L)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Instr(Instr), .BrCond(BrCond),
    .PC(PC), .IR(IR), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Done(Done), .CycleCnt(CycleCnt)
  );
  always #5 Clk = ~Clk;
  typedef struct {
    logic [8:0] instr;
    logic       br;
    int         nxt_pc, cyc, rw, mr, mw;
  } vec_t;
  typedef struct packed {
    logic [9:0]  pc;
    logic [8:0]  ir;
    logic        irw, rw, mr, mw, dn;
    logic [15:0] cnt;
  } exp_t;
  vec_t tbl [10];
  exp_t q [$];
  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask
  task automatic reset_dut();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask
  task automatic start_dut();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask
  task automatic fill_halt();
    for (int i = 0; i < 1024; i++) begin
      rom[i] = HW;
      brc[i] = 1'b0;
    end
  endtask
  function automatic exp_t mk(int pc, logic [8:0] ir, logic irw, logic rw, logic mr, logic mw, logic dn, int cnt);
    exp_t e;
    e.pc = 10'(pc); e.ir = ir; e.irw = irw; e.rw = rw; e.mr = mr; e.mw = mw; e.dn = dn;
    e.cnt = CNT_EN ? 16'(cnt) : 16'h0;
    return e;
  endfunction
  // Expected per-cycle trace of a run from PC 0, one instruction at a time.
  task automatic build(input int cap);
    int pc = 0, cnt = 0, off;
    logic [8:0] ir = '0, ins;
    logic [2:0] op;
    q.delete();
    while (q.size() < cap) begin
      ins = rom[pc];
      op  = ins[8:6];
      q.push_back(mk(pc, ir, 1, 0, 0, 0, 0, cnt)); cnt++;
      ir = ins;
      q.push_back(mk(pc, ir, 0, 0, 0, 0, 0, cnt)); cnt++;
      if (ins == HW) begin
        while (q.size() < cap) q.push_back(mk(pc, ir, 0, 0, 0, 0, 1, cnt));
      end else if (op == 3'b011 || op == 3'b101) begin
        off = !brc[pc] ? 1 : ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        pc  = (pc + off) & 1023;
      end else begin
        if (op == 3'b110 || op == 3'b111)
          for (int i = 0; i < L; i++) begin
            q.push_back(mk(pc, ir, 0, 0, op == 3'b110, op == 3'b111 && i == L - 1, 0, cnt));
            cnt++;
          end
        if (op != 3'b111) begin
          q.push_back(mk(pc, ir, 0, 1, 0, 0, 0, cnt));
          cnt++;
        end
        pc = (pc + 1) & 1023;
      end
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    int cyc, rw, mr, mw;
    exp_t act;
    tbl[0] = '{9'b001_000101, 1'b0, 1, 3, 1, 0, 0};
    tbl[1] = '{9'b000_000001, 1'b0, 1, 3, 1, 0, 0};
    tbl[2] = '{9'b011_111110, 1'b1, 1022, 2, 0, 0, 0};
    tbl[3] = '{9'b011_111110, 1'b0, 1, 2, 0, 0, 0};
    tbl[4] = '{9'b101_011111, 1'b1, 31, 2, 0, 0, 0};
    tbl[5] = '{9'b101_100000, 1'b1, 992, 2, 0, 0, 0};
    tbl[6] = '{9'b111_000000, 1'b0, 1, 2 + L, 0, 0, 1};
    tbl[7] = '{9'b110_000000, 1'b0, 1, 3 + L, 1, L, 0};
    tbl[8] = '{9'b100_111111, 1'b1, 1, 3, 1, 0, 0};
    tbl[9] = '{9'b010_000000, 1'b1, 1, 3, 1, 0, 0};
    fill_halt();
    @(negedge Clk);
    tick();
    chk("reset_state", {PC, IR, IRWrite, RegWrite, MemRead, MemWrite, Done, CycleCnt}, 0);
    Reset = 1'b0;
    tick();
    chk("idle_hold", {PC, IRWrite, Done}, 0);
    for (int t = 0; t < 10; t++) begin
      fill_halt();
      rom[0] = tbl[t].instr;
      brc[0] = tbl[t].br;
      reset_dut();
      start_dut();
      chk($sformatf("t%0d_fetch", t), {IRWrite, PC}, {1'b1, 10'd0});
      cyc = 0; rw = 0; mr = 0; mw = 0;
      do begin
        tick();
        cyc++;
        rw += int'(RegWrite); mr += int'(MemRead); mw += int'(MemWrite);
      end while (!IRWrite && cyc < 20);
      chk($sformatf("t%0d_latency", t), cyc, tbl[t].cyc);
      chk($sformatf("t%0d_next_pc", t), PC, tbl[t].nxt_pc);
      chk($sformatf("t%0d_strobes", t), {rw, mr, mw}, {tbl[t].rw, tbl[t].mr, tbl[t].mw});
    end
    // ALU then HALT: Done timing, hold, and restart
    fill_halt();
    rom[0] = 9'b001_000101;
    reset_dut();
    start_dut();
    cyc = 0; rw = 0;
    while (!Done && cyc < 20) begin
      tick();
      cyc++;
      rw += int'(RegWrite);
    end
    chk("done_latency", cyc, 5);
    chk("halt_pc", PC, 1);
    chk("halt_regwrite_pulses", rw, 1);
    chk("halt_cyclecnt", CycleCnt, CNT_EN ? 5 : 0);
    repeat (3) tick();
    chk("halt_hold", {Done, CycleCnt}, {1'b1, CNT_EN ? 16'd5 : 16'd0});
    start_dut();
    chk("restart", {IRWrite, Done, PC, CycleCnt}, {1'b1, 1'b0, 10'd0, 16'd0});
    tick();
    chk("restart_cnt", CycleCnt, CNT_EN ? 1 : 0);
    // Branch at PC 5 with offset -2, taken and not taken
    for (int b = 0; b < 2; b++) begin
      fill_halt();
      for (int i = 0; i < 5; i++) rom[i] = 9'b001_000000;
      rom[5] = 9'b011_111110;
      brc[5] = b == 0;
      reset_dut();
      start_dut();
      cyc = 0;
      while (!(IRWrite && PC == 5) && cyc < 40) begin
        tick();
        cyc++;
      end
      chk($sformatf("br%0d_reach", b), PC, 5);
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (!IRWrite && cyc < 20);
      chk($sformatf("br%0d_latency", b), cyc, 2);
      chk($sformatf("br%0d_target", b), PC, b == 0 ? 3 : 6);
    end
    // Reset during the second MEM cycle of a store
    fill_halt();
    rom[0] = 9'b111_000000;
    reset_dut();
    start_dut();
    mw = 0;
    repeat (3) begin
      tick();
      mw += int'(MemWrite);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_strobes", {MemWrite, MemRead, IRWrite, Done, PC}, 0);
    chk("abort_no_memwrite", mw, 0);
    tick();
    chk("abort_idle", {IRWrite, PC}, 0);
    start_dut();
    chk("abort_restart", {IRWrite, PC}, {1'b1, 10'd0});
    // Random programs against the instruction-level model
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 1024; i++) begin
        rom[i] = ($urandom_range(0, 7) == 0) ? HW : 9'($urandom);
        brc[i] = 1'($urandom);
      end
      build(120);
      reset_dut();
      start_dut();
      for (int k = 0; k < 120; k++) begin
        act = {PC, IR, IRWrite, RegWrite, MemRead, MemWrite, Done, CycleCnt};
        chk($sformatf("rand%0d_cyc%0d", p, k), act, q[k]);
        tick();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
